// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per cycle, LSB first.
// Operands are latched when start is accepted in IDLE. The result and final
// borrow are loaded together on the last RUN edge and then held.
// Optional feature: define SERIAL_SUBTRACTOR_ZERO_FLAG_EN to add output 'zero',
// which flags a loaded diff of 0.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             d_bit;
  logic             bw_bit;
  logic [WIDTH-1:0] res_final;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  // One-bit full subtractor on the current LSBs of the operand shift registers.
  always_comb begin
    d_bit     = a_q[0] ^ b_q[0] ^ bw_q;
    bw_bit    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
    // Result bits enter at the MSB, so after WIDTH shifts bit 0 holds the first bit.
    res_final = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bw_d  = bw_bit;
        res_d = res_final;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d   = res_final;
          borrow_d = bw_bit;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
          zero_d   = (res_final == '0);
`endif
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy       = (state_q == StRun);
    done       = (state_q == StDone);
    diff       = diff_q;
    borrow_out = borrow_q;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    zero       = zero_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic         zero;
  logic         res_zero;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge. Mode 0: plain; mode 1: re-assert start with new
  // operands during RUN and DONE; mode 2: scramble a/b every cycle after acceptance.
  // Returns at a falling edge after a quiet tail of 10 cycles.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input int mode,
                        output logic [W-1:0] r_diff, output logic r_bw, output int lat,
                        output int busy_cnt, output int extra, output int unstable);
    logic [W-1:0] d0;
    int n;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(negedge clk);
    start    = 1'b0;
    d0       = diff;
    n        = 0;
    busy_cnt = 0;
    unstable = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (diff !== d0) unstable++;
      if (mode == 1) begin
        start = 1'b1;
        a     = ~op_a;
        b     = ~op_b;
      end else if (mode == 2) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    lat    = n;
    r_diff = diff;
    r_bw   = borrow_out;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    res_zero = zero;
`endif
    if (mode == 1) begin
      start = 1'b1;
      a     = 8'h01;
      b     = 8'hFE;
    end
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) extra++;
      if (diff !== r_diff) unstable++;
      @(negedge clk);
    end
  endtask

  task automatic op_and_check(input string tag, input logic [W-1:0] op_a,
                              input logic [W-1:0] op_b, input int mode,
                              input logic [W-1:0] exp_diff, input logic exp_bw);
    logic [W-1:0] r_diff;
    logic         r_bw;
    int lat, busy_cnt, extra, unstable;
    run_op(op_a, op_b, mode, r_diff, r_bw, lat, busy_cnt, extra, unstable);
    check({tag, " diff"}, 32'(r_diff), 32'(exp_diff));
    check({tag, " borrow_out"}, 32'(r_bw), 32'(exp_bw));
    check({tag, " done_edges_after_accept"}, lat, W);
    check({tag, " busy_cycles"}, busy_cnt, W);
    check({tag, " extra_busy_or_done"}, extra, 0);
    check({tag, " diff_unstable"}, unstable, 0);
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    check({tag, " zero"}, 32'(res_zero), 32'(exp_diff == '0));
`endif
  endtask

  initial begin
    logic [W-1:0] r_diff;
    logic         r_bw;
    int lat, busy_cnt, extra, unstable;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset diff", 32'(diff), 0);
    check("reset borrow_out", 32'(borrow_out), 0);
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    check("reset zero", 32'(zero), 0);
`endif
    rst = 1'b0;

    op_and_check("5a-3c", 8'h5A, 8'h3C, 0, 8'h1E, 1'b0);
    op_and_check("00-01", 8'h00, 8'h01, 0, 8'hFF, 1'b1);

    // Abort in the 4th RUN cycle: diff/borrow were FF/1 and must clear.
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun busy before rst", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort diff", 32'(diff), 0);
    check("abort borrow_out", 32'(borrow_out), 0);
    rst = 1'b0;
    // Start driven for the very first edge after reset release.
    op_and_check("10-20 after rst", 8'h10, 8'h20, 0, 8'hF0, 1'b1);

    op_and_check("80-7f", 8'h80, 8'h7F, 0, 8'h01, 1'b0);
    op_and_check("ff-ff", 8'hFF, 8'hFF, 0, 8'h00, 1'b0);
    op_and_check("9c-47 restart ignored", 8'h9C, 8'h47, 1, 8'h55, 1'b0);
    op_and_check("c3-5e scrambled", 8'hC3, 8'h5E, 2, 8'h65, 1'b0);
    op_and_check("21-a7 scrambled", 8'h21, 8'hA7, 2, 8'h7A, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
